decode_queue_stage: RTL and testbench
=====================================

// Module: decode_queue_stage
// PURPOSE
//  Parametrised successor to the single-register decode stage: a DEPTH-entry instruction queue
//  decouples fetch from decode, and the queue head is decoded into a registered output bundle.
//  Sits between the fetch stage and register-read; absorbs fetch bursts while decode stalls.
//  Generates illegal-instruction traps and supports flush and stall from the pipeline controller.
// PARAMETERS
//  DEPTH       4   queue entries; power of two, >= 2
//  XLEN        32  pc / trap value width
//  INSN_WIDTH  32  instruction width
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           synchronous, active-high reset
//  flush          in   1           discard queue and output register
//  stall          in   1           hold output register, no dequeue (controller idStall)
//  in_valid       in   1           fetch bundle valid
//  in_ready       out  1           queue can accept (count < DEPTH)
//  in_pc          in   XLEN        fetch pc
//  in_insn        in   INSN_WIDTH  fetched instruction
//  in_trap        in   TrapInfo    fetch-side trap (valid/cause/value)
//  out_valid      out  1           decoded bundle valid
//  out_pc/out_insn out XLEN/INSN_WIDTH  registered pc / raw instruction
//  out_op         out  Op          Decode(head insn), registered
//  out_csr_addr   out  12          insn[31:20]
//  out_src1/2/3   out  5 each      insn[19:15] / insn[24:20] / insn[31:27]
//  out_dst        out  5           insn[11:7]
//  out_trap       out  TrapInfo    trap carried with bundle
//  count          out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  - Reset (rst=1): all outputs zero, count=0, rd/wr pointers 0; in_ready=0 during reset cycle.
//  - Enqueue: push = in_valid && in_ready && !flush; in_ready = (count < DEPTH) from registered
//    count only (no same-cycle pop credit; full queue + pop still reports in_ready=0).
//  - Dequeue: pop = !stall && !flush && count!=0; output register loads decoded head on pop.
//  - !stall && count==0 && !flush: output register loads a bubble (all fields zero).
//  - stall=1: output register and queue head hold; enqueue continues while not full.
//  - Latency: bundle pushed at edge t is visible at out_* after edge t+1 (empty queue, no stall).
//  - Push and pop in same cycle: count unchanged, both pointers advance; pointers wrap mod DEPTH.
//  - Decode: head fields sliced as listed; op = Decode(head insn).
//  - Trap: if head trap.valid=0 and op.isUnknown -> out_trap = {valid=1,
//    cause=ExceptionCode_IllegalInsn, value=zero-extended insn}; otherwise head trap passed as-is.
//    A fetch trap always takes precedence over illegal instruction.
//  - flush=1 (priority over stall and push): queue emptied (count=0, pointers reset), output
//    register zeroed; any in_valid bundle in the flush cycle is dropped.
//  - rst has priority over flush; reset mid-burst discards everything, same as power-up.
//  - Queue storage entries are not cleared on reset/flush; only pointers/count.
//  - No combinational path from in_* to out_*; in_ready depends only on state.
// TESTING
//  - Single insn: push pc=0x100 insn=0x00500093 (addi x1,x0,5) -> next-next cycle out_valid=1,
//    out_pc=0x100, out_dst=1, out_src1=0, out_trap.valid=0.
//  - Fill: stall=1, push 4 insns (DEPTH=4) -> count=4, in_ready=0; 5th in_valid not accepted;
//    release stall -> 4 bundles exit in order on 4 consecutive cycles, no gaps, then bubble.
//  - Illegal: push insn=0x00000000 pc=0x200 -> out_trap={1,IllegalInsn,0x0}; push with
//    in_trap.valid=1 cause=InsnAccessFault and insn=0 -> fetch trap passed unchanged.
//  - Flush: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, nothing
//    emitted from dropped entries; subsequent push appears after normal 2-edge latency.
//  - Simultaneous push/pop at count=2 over 10 cycles -> count stays 2, pointer wrap past
//    DEPTH-1 keeps order (pcs 0x0,0x4,... emerge strictly increasing).
//  - Reset mid-operation: rst=1 with count=3, stall=1 -> next cycle all outputs 0, count=0.

Source files
------------

// File: rtl/decode_queue_stage.sv
// Instruction queue between fetch and decode; the queue head is decoded into a registered bundle.
// Latency: push at edge t appears on out_* after edge t+1; in_ready from registered occupancy only.
package decode_queue_pkg;
    localparam int TRAP_VALUE_W = 32;

    localparam logic [3:0] EXC_INSN_ACCESS_FAULT = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSN      = 4'd2;

    typedef enum logic [3:0] {
        OP_NONE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
        OP_STORE, OP_OPIMM, OP_OP, OP_MISCMEM, OP_SYSTEM
    } op_kind_e;

    typedef struct packed {
        logic     is_unknown;
        op_kind_e kind;
    } op_t;

    typedef struct packed {
        logic                    valid;
        logic [3:0]              cause;
        logic [TRAP_VALUE_W-1:0] value;
    } trap_t;

    function automatic op_t decode(input logic [6:0] opcode);
        op_t op;
        op = '{is_unknown: 1'b0, kind: OP_NONE};
        case (opcode)
            7'b0110111: op.kind = OP_LUI;
            7'b0010111: op.kind = OP_AUIPC;
            7'b1101111: op.kind = OP_JAL;
            7'b1100111: op.kind = OP_JALR;
            7'b1100011: op.kind = OP_BRANCH;
            7'b0000011: op.kind = OP_LOAD;
            7'b0100011: op.kind = OP_STORE;
            7'b0010011: op.kind = OP_OPIMM;
            7'b0110011: op.kind = OP_OP;
            7'b0001111: op.kind = OP_MISCMEM;
            7'b1110011: op.kind = OP_SYSTEM;
            default:    op.is_unknown = 1'b1;
        endcase
        return op;
    endfunction
endpackage

module decode_queue_stage
    import decode_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int INSN_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [INSN_WIDTH-1:0]   in_insn,
    input  trap_t                   in_trap,
    output logic                    out_valid,
    output logic [XLEN-1:0]         out_pc,
    output logic [INSN_WIDTH-1:0]   out_insn,
    output op_t                     out_op,
    output logic [11:0]             out_csr_addr,
    output logic [4:0]              out_src1,
    output logic [4:0]              out_src2,
    output logic [4:0]              out_src3,
    output logic [4:0]              out_dst,
    output trap_t                   out_trap,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]       pc_mem   [DEPTH];
    logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
    trap_t                 trap_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;
    logic [INSN_WIDTH-1:0] head_insn;
    op_t              head_op;
    trap_t            head_trap;

    assign in_ready  = !rst && (count < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready && !flush;
    assign pop       = !stall && !flush && (count != '0);
    assign head_insn = insn_mem[rd_ptr];

    // A fetch-side trap always wins over an illegal-instruction trap.
    always_comb begin
        head_op   = decode(head_insn[6:0]);
        head_trap = trap_mem[rd_ptr];
        if (!head_trap.valid && head_op.is_unknown) begin
            head_trap.valid = 1'b1;
            head_trap.cause = EXC_ILLEGAL_INSN;
            head_trap.value = TRAP_VALUE_W'(head_insn);
        end
    end

    // Storage is not cleared on reset or flush; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            insn_mem[wr_ptr] <= in_insn;
            trap_mem[wr_ptr] <= in_trap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_insn     <= '0;
            out_op       <= '0;
            out_csr_addr <= '0;
            out_src1     <= '0;
            out_src2     <= '0;
            out_src3     <= '0;
            out_dst      <= '0;
            out_trap     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (!stall) begin
                if (pop) begin
                    out_valid    <= 1'b1;
                    out_pc       <= pc_mem[rd_ptr];
                    out_insn     <= head_insn;
                    out_op       <= head_op;
                    out_csr_addr <= head_insn[31:20];
                    out_src1     <= head_insn[19:15];
                    out_src2     <= head_insn[24:20];
                    out_src3     <= head_insn[31:27];
                    out_dst      <= head_insn[11:7];
                    out_trap     <= head_trap;
                end else begin
                    out_valid    <= 1'b0;
                    out_pc       <= '0;
                    out_insn     <= '0;
                    out_op       <= '0;
                    out_csr_addr <= '0;
                    out_src1     <= '0;
                    out_src2     <= '0;
                    out_src3     <= '0;
                    out_dst      <= '0;
                    out_trap     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: directed vector table, push/pop wrap sequence, random vs queue model.
module tb_decode_queue_stage;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] ADDI = 32'h00500093;

    logic        clk, rst, flush, stall, in_valid, in_ready;
    logic [31:0] in_pc, in_insn;
    trap_t       in_trap;
    logic        out_valid;
    logic [31:0] out_pc, out_insn;
    op_t         out_op;
    logic [11:0] out_csr_addr;
    logic [4:0]  out_src1, out_src2, out_src3, out_dst;
    trap_t       out_trap;
    logic [2:0]  count;

    decode_queue_stage #(.DEPTH(DEPTH), .XLEN(32), .INSN_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
        .in_trap(in_trap), .out_valid(out_valid), .out_pc(out_pc), .out_insn(out_insn),
        .out_op(out_op), .out_csr_addr(out_csr_addr), .out_src1(out_src1),
        .out_src2(out_src2), .out_src3(out_src3), .out_dst(out_dst),
        .out_trap(out_trap), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetch bundles plus the expected output bundle.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        trap_t       trap;
    } ent_t;

    ent_t        q[$];
    logic        m_valid;
    logic [31:0] m_pc, m_insn;
    op_t         m_op;
    trap_t       m_trap;
    logic        m_rst;

    function automatic op_t model_decode(input logic [31:0] insn);
        logic [6:0] tbl [11];
        op_t        op;
        tbl = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        op.is_unknown = 1'b1;
        op.kind       = OP_NONE;
        for (int i = 0; i < 11; i++)
            if (insn[6:0] == tbl[i]) begin
                op.is_unknown = 1'b0;
                op.kind       = op_kind_e'(i + 1);
            end
        return op;
    endfunction

    task automatic model_zero();
        m_valid = 1'b0; m_pc = '0; m_insn = '0; m_op = '0; m_trap = '0;
    endtask

    task automatic model_step(input logic r, f, s, v, input logic [31:0] p, ins, input trap_t t);
        ent_t e;
        logic rdy;
        m_rst = r;
        if (r || f) begin
            q.delete();
            model_zero();
        end else begin
            rdy = (q.size() < DEPTH);
            if (!s) begin
                if (q.size() > 0) begin
                    e       = q.pop_front();
                    m_valid = 1'b1;
                    m_pc    = e.pc;
                    m_insn  = e.insn;
                    m_op    = model_decode(e.insn);
                    m_trap  = e.trap;
                    if (!e.trap.valid && m_op.is_unknown)
                        m_trap = '{valid: 1'b1, cause: EXC_ILLEGAL_INSN, value: e.insn};
                end else begin
                    model_zero();
                end
            end
            if (v && rdy) q.push_back('{pc: p, insn: ins, trap: t});
        end
    endtask

    task automatic model_compare();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_pc", 64'(out_pc), 64'(m_pc));
        chk("out_insn", 64'(out_insn), 64'(m_insn));
        chk("out_op", 64'(out_op), 64'(m_op));
        chk("out_trap", 64'(out_trap), 64'(m_trap));
        chk("out_csr_addr", 64'(out_csr_addr), 64'(m_insn[31:20]));
        chk("out_src1", 64'(out_src1), 64'(m_insn[19:15]));
        chk("out_src2", 64'(out_src2), 64'(m_insn[24:20]));
        chk("out_src3", 64'(out_src3), 64'(m_insn[31:27]));
        chk("out_dst", 64'(out_dst), 64'(m_insn[11:7]));
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(!m_rst && q.size() < DEPTH));
    endtask

    task automatic cyc(input logic r, f, s, v, input logic [31:0] p, ins, input trap_t t);
        rst = r; flush = f; stall = s; in_valid = v; in_pc = p; in_insn = ins; in_trap = t;
        @(posedge clk);
        #1;
        model_step(r, f, s, v, p, ins, t);
        model_compare();
    endtask

    typedef struct {
        logic        r, f, s, v;
        logic [31:0] pc, insn;
        trap_t       trap;
        logic        xv;
        logic [31:0] xpc;
        trap_t       xtrap;
        int          xcnt;
        logic        xrdy;
    } vec_t;

    function automatic vec_t mk(input int r, f, s, v, input logic [31:0] pc, insn,
                                input int tv, tc, input logic [31:0] tval,
                                input int xv, input logic [31:0] xpc, input int xtv, xtc,
                                input logic [31:0] xtval, input int xcnt, xrdy);
        vec_t e;
        e.r = r[0]; e.f = f[0]; e.s = s[0]; e.v = v[0];
        e.pc = pc; e.insn = insn;
        e.trap = '{valid: tv[0], cause: tc[3:0], value: tval};
        e.xv = xv[0]; e.xpc = xpc;
        e.xtrap = '{valid: xtv[0], cause: xtc[3:0], value: xtval};
        e.xcnt = xcnt; e.xrdy = xrdy[0];
        return e;
    endfunction

    vec_t vt[$];

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_insn = '0; in_trap = '0;
        model_zero();
        m_rst = 1'b1;

        //          r f s v  pc        insn   tv tc tval     xv xpc       xtv xtc xtval    cnt rdy
        vt.push_back(mk(1,0,0,0, 0,       0,     0, 0, 0,     0, 0,        0, 0, 0,        0, 0));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     0, 0,        0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,0,1, 32'h100, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        1, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     1, 32'h100,  0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     0, 0,        0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,0,1, 32'h200, 0,     0, 0, 0,     0, 0,        0, 0, 0,        1, 1));
        vt.push_back(mk(0,0,0,1, 32'h300, 0,     1, 1, 32'h300, 1, 32'h200, 1, 2, 0,       1, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     1, 32'h300,  1, 1, 32'h300,  0, 1));
        vt.push_back(mk(0,0,1,1, 32'h400, ADDI,  0, 0, 0,     1, 32'h300,  1, 1, 32'h300,  1, 1));
        vt.push_back(mk(0,0,1,1, 32'h404, ADDI,  0, 0, 0,     1, 32'h300,  1, 1, 32'h300,  2, 1));
        vt.push_back(mk(0,0,1,1, 32'h408, ADDI,  0, 0, 0,     1, 32'h300,  1, 1, 32'h300,  3, 1));
        vt.push_back(mk(0,0,1,1, 32'h40c, ADDI,  0, 0, 0,     1, 32'h300,  1, 1, 32'h300,  4, 0));
        vt.push_back(mk(0,0,1,1, 32'h410, ADDI,  0, 0, 0,     1, 32'h300,  1, 1, 32'h300,  4, 0));
        vt.push_back(mk(0,0,0,1, 32'h414, ADDI,  0, 0, 0,     1, 32'h400,  0, 0, 0,        3, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     1, 32'h404,  0, 0, 0,        2, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     1, 32'h408,  0, 0, 0,        1, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     1, 32'h40c,  0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     0, 0,        0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,1,1, 32'h500, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        1, 1));
        vt.push_back(mk(0,0,1,1, 32'h504, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        2, 1));
        vt.push_back(mk(0,0,1,1, 32'h508, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        3, 1));
        vt.push_back(mk(0,1,1,1, 32'h50c, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     0, 0,        0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,0,1, 32'h600, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        1, 1));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     1, 32'h600,  0, 0, 0,        0, 1));
        vt.push_back(mk(0,0,1,1, 32'h700, ADDI,  0, 0, 0,     1, 32'h600,  0, 0, 0,        1, 1));
        vt.push_back(mk(0,0,1,1, 32'h704, ADDI,  0, 0, 0,     1, 32'h600,  0, 0, 0,        2, 1));
        vt.push_back(mk(0,0,1,1, 32'h708, ADDI,  0, 0, 0,     1, 32'h600,  0, 0, 0,        3, 1));
        vt.push_back(mk(1,0,1,1, 32'h70c, ADDI,  0, 0, 0,     0, 0,        0, 0, 0,        0, 0));
        vt.push_back(mk(0,0,0,0, 0,       0,     0, 0, 0,     0, 0,        0, 0, 0,        0, 1));

        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].f, vt[i].s, vt[i].v, vt[i].pc, vt[i].insn, vt[i].trap);
            chk($sformatf("vec%0d valid", i), 64'(out_valid), 64'(vt[i].xv));
            chk($sformatf("vec%0d pc", i), 64'(out_pc), 64'(vt[i].xpc));
            chk($sformatf("vec%0d trap", i), 64'(out_trap), 64'(vt[i].xtrap));
            chk($sformatf("vec%0d count", i), 64'(count), 64'(vt[i].xcnt));
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vt[i].xrdy));
            if (i == 3) begin
                chk("addi dst", 64'(out_dst), 64'd1);
                chk("addi src1", 64'(out_src1), 64'd0);
            end
        end

        // Steady push+pop at occupancy 2; pointers wrap several times.
        cyc(0, 0, 1, 1, 32'h0, ADDI, '0);
        cyc(0, 0, 1, 1, 32'h4, ADDI, '0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 1, 32'h8 + 32'(4 * k), ADDI, '0);
            chk($sformatf("pp%0d count", k), 64'(count), 64'd2);
            chk($sformatf("pp%0d valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("pp%0d pc", k), 64'(out_pc), 64'(4 * k));
        end
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, '0, '0, '0);

        for (int n = 0; n < 800; n++) begin
            logic        r, f, s, v;
            logic [31:0] ins;
            trap_t       t;
            r = ($urandom % 60) == 0;
            f = ($urandom % 25) == 0;
            s = ($urandom % 3) == 0;
            v = ($urandom % 4) != 0;
            case ($urandom % 4)
                0:       ins = $urandom;
                1:       ins = '0;
                default: ins = {$urandom_range(0, 32'h1ffffff) , 7'h13};
            endcase
            t.valid = ($urandom % 6) == 0;
            t.cause = 4'($urandom);
            t.value = $urandom;
            cyc(r, f, s, v, $urandom, ins, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
